// File: rtl/hidden_cpu_program_feeder.sv
// rtl/hidden_cpu_program_feeder.sv - program store and pin driver feeding an 8-bit CPU
// Define FEEDER_LOOP_EN to replay the program continuously until abort.
module hidden_cpu_program_feeder #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int RST_CYCLES  = 2,
  parameter int HALF_PERIOD = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [5:0]    load_data,
  input  logic          load_clear,
  input  logic          start,
  input  logic          abort,
  output logic [7:0]    cpu_io_in,
  input  logic [7:0]    cpu_io_out,
  output logic [7:0]    sample,
  output logic          sample_valid,
  output logic [AW-1:0] sample_idx,
  output logic          busy,
  output logic          done
);
  localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);
  localparam logic [HW-1:0] H_LAST = HW'(HALF_PERIOD - 1);
  localparam logic [RW-1:0] R_LAST = RW'((RST_CYCLES > 0) ? RST_CYCLES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_RSTCPU, S_SETUP, S_PULSE, S_FINISH} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   ptr_q, ptr_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          clk_hi_q, clk_hi_d;
  logic [7:0]    cpu_io_q, cpu_io_d;
  logic [7:0]    sample_q, sample_d;
  logic [AW-1:0] sample_idx_q, sample_idx_d;
  logic          sample_valid_q, sample_valid_d;
  logic          done_q, done_d;
  logic [5:0]    mem_q [DEPTH];
  logic          mem_we;
  logic          last_half;

  // Program store is deliberately not reset; count_q gates every access.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[count_q[AW-1:0]] <= load_data;
    end
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    ptr_d          = ptr_q;
    hcnt_d         = hcnt_q;
    rcnt_d         = rcnt_q;
    clk_hi_d       = clk_hi_q;
    sample_d       = sample_q;
    sample_idx_d   = sample_idx_q;
    sample_valid_d = 1'b0;
    done_d         = 1'b0;
    mem_we         = 1'b0;
    cpu_io_d       = 8'h00;
    last_half      = (hcnt_q == H_LAST);
    load_ready     = (state_q == S_IDLE) && (count_q != FULL);

    unique case (state_q)
      S_IDLE: begin
        if (start && (count_q != '0)) begin
          ptr_d    = '0;
          hcnt_d   = '0;
          rcnt_d   = '0;
          clk_hi_d = 1'b0;
          state_d  = (RST_CYCLES > 0) ? S_RSTCPU : S_SETUP;
        end else if (load_clear) begin
          count_d = '0;
        end else if (load_valid && load_ready) begin
          mem_we  = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      S_RSTCPU: begin
        if (last_half) begin
          hcnt_d   = '0;
          clk_hi_d = ~clk_hi_q;
          if (clk_hi_q) begin
            if (rcnt_q == R_LAST) begin
              state_d = S_SETUP;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      S_SETUP: begin
        if (last_half) begin
          hcnt_d  = '0;
          state_d = S_PULSE;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      S_PULSE: begin
        if (last_half) begin
          hcnt_d         = '0;
          sample_d       = cpu_io_out;
          sample_idx_d   = ptr_q[AW-1:0];
          sample_valid_d = 1'b1;
          if (ptr_q == count_q - 1'b1) begin
`ifdef FEEDER_LOOP_EN
            ptr_d   = '0;
            state_d = S_SETUP;
`else
            state_d = S_FINISH;
`endif
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = S_SETUP;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d        = S_IDLE;
      sample_d       = sample_q;
      sample_idx_d   = sample_idx_q;
      sample_valid_d = 1'b0;
      done_d         = 1'b0;
    end

    // Pins are registered from the next state so the CPU clock bit never glitches.
    unique case (state_d)
      S_RSTCPU: cpu_io_d = {6'b0, 1'b1, clk_hi_d};
      S_SETUP:  cpu_io_d = {mem_q[ptr_d[AW-1:0]], 2'b00};
      S_PULSE:  cpu_io_d = {mem_q[ptr_d[AW-1:0]], 2'b01};
      default:  cpu_io_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      ptr_q          <= '0;
      hcnt_q         <= '0;
      rcnt_q         <= '0;
      clk_hi_q       <= 1'b0;
      cpu_io_q       <= 8'h00;
      sample_q       <= 8'h00;
      sample_idx_q   <= '0;
      sample_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      ptr_q          <= ptr_d;
      hcnt_q         <= hcnt_d;
      rcnt_q         <= rcnt_d;
      clk_hi_q       <= clk_hi_d;
      cpu_io_q       <= cpu_io_d;
      sample_q       <= sample_d;
      sample_idx_q   <= sample_idx_d;
      sample_valid_q <= sample_valid_d;
      done_q         <= done_d;
    end
  end

  assign cpu_io_in    = cpu_io_q;
  assign sample       = sample_q;
  assign sample_idx   = sample_idx_q;
  assign sample_valid = sample_valid_q;
  assign done         = done_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_hidden_cpu_program_feeder.sv
// tb/tb_hidden_cpu_program_feeder.sv - directed self-checking bench for hidden_cpu_program_feeder
// Default build checks single runs; with FEEDER_LOOP_EN it checks continuous replay.
module tb_hidden_cpu_program_feeder;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic          load_ready;
  logic [5:0]    load_data;
  logic          load_clear;
  logic          start;
  logic          abort;
  logic [7:0]    cpu_io_in;
  logic [7:0]    cpu_io_out;
  logic [7:0]    sample;
  logic          sample_valid;
  logic [AW-1:0] sample_idx;
  logic          busy;
  logic          done;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  hidden_cpu_program_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .load_clear   (load_clear),
    .start        (start),
    .abort        (abort),
    .cpu_io_in    (cpu_io_in),
    .cpu_io_out   (cpu_io_out),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_idx   (sample_idx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // CPU stand-in: answers 8'h10 + program index for the instruction on the bus.
  always_comb begin
    case (cpu_io_in[7:2])
      6'h15:   cpu_io_out = 8'h10;
      6'h2A:   cpu_io_out = 8'h11;
      6'h3F:   cpu_io_out = 8'h12;
      default: cpu_io_out = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [5:0] w);
    load_valid = 1'b1;
    load_data  = w;
    tick(1);
    load_valid = 1'b0;
  endtask

  initial begin
    logic [7:0]    seq [12];
    logic [7:0]    exp_sample;
    logic [AW-1:0] last_idx;
    int            nsv;
    bit            seen_done;
    bit            bad;

    seq = '{8'h02, 8'h03, 8'h02, 8'h03, 8'h54, 8'h55, 8'hA8, 8'hA9, 8'hFC, 8'hFD, 8'h00, 8'h00};
    rst = 1'b0; load_valid = 1'b0; load_data = '0; load_clear = 1'b0; start = 1'b0; abort = 1'b0;
    tick(2);
    chk("rst_cpu_io_in", cpu_io_in, 8'h00);
    chk("rst_load_ready", load_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sample_valid", sample_valid, 1'b0);
    chk("rst_sample", sample, 8'h00);
    chk("rst_sample_idx", sample_idx, 4'd0);
    rst = 1'b1;
    tick(1);

`ifdef FEEDER_LOOP_EN
    load_word(6'h15);
    load_word(6'h2A);
    start = 1'b1; tick(1); start = 1'b0;
    nsv = 0; bad = 1'b0; seen_done = 1'b0;
    for (int c = 0; c < 40 && nsv < 4; c++) begin
      if (done) seen_done = 1'b1;
      if (nsv > 0 && cpu_io_in[1]) bad = 1'b1;
      if (sample_valid) begin
        chk("loop_sample_idx", sample_idx, nsv % 2);
        nsv++;
      end
      tick(1);
    end
    chk("loop_samples_seen", nsv, 4);
    chk("loop_no_cpu_reset", bad, 1'b0);
    chk("loop_no_done", seen_done, 1'b0);
    chk("loop_busy", busy, 1'b1);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("loop_abort_busy", busy, 1'b0);
    chk("loop_abort_pins", cpu_io_in, 8'h00);
`else
    load_word(6'h15);
    load_word(6'h2A);
    load_word(6'h3F);
    start = 1'b1; tick(1); start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("run_cpu_io_in[%0d]", i), cpu_io_in, seq[i]);
      chk($sformatf("run_busy[%0d]", i), busy, (i < 11));
      chk($sformatf("run_done[%0d]", i), done, (i == 11));
      chk($sformatf("run_sample_valid[%0d]", i), sample_valid, (i == 6 || i == 8 || i == 10));
      if (i == 6 || i == 8 || i == 10) begin
        exp_sample = 8'h10 + 8'((i - 6) / 2);
        chk($sformatf("run_sample[%0d]", i), sample, exp_sample);
        chk($sformatf("run_sample_idx[%0d]", i), sample_idx, (i - 6) / 2);
      end
      tick(1);
    end
    chk("run_done_one_cycle", done, 1'b0);

    load_clear = 1'b1; tick(1); load_clear = 1'b0;
    for (int i = 0; i < 15; i++) load_word(6'(i + 1));
    chk("fill15_load_ready", load_ready, 1'b1);
    load_word(6'h3C);
    chk("fill16_load_ready", load_ready, 1'b0);
    load_word(6'h07);
    chk("fill17_load_ready", load_ready, 1'b0);
    start = 1'b1; tick(1); start = 1'b0;
    nsv = 0; last_idx = '0; seen_done = 1'b0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      if (sample_valid) begin
        nsv++;
        last_idx = sample_idx;
      end
      if (done) seen_done = 1'b1;
      tick(1);
    end
    chk("full_run_done", seen_done, 1'b1);
    chk("full_run_samples", nsv, 16);
    chk("full_run_last_idx", last_idx, 4'd15);
    load_clear = 1'b1; tick(1); load_clear = 1'b0;
    chk("clear_load_ready", load_ready, 1'b1);

    start = 1'b1; tick(1); start = 1'b0;
    chk("empty_start_busy", busy, 1'b0);
    chk("empty_start_pins", cpu_io_in, 8'h00);
    seen_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (done || busy) seen_done = 1'b1;
      tick(1);
    end
    chk("empty_start_no_activity", seen_done, 1'b0);

    load_word(6'h15);
    load_word(6'h2A);
    load_word(6'h3F);
    start = 1'b1; tick(1); start = 1'b0;
    tick(6);
    chk("abort_at_setup2", cpu_io_in, 8'hA8);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("abort_pins", cpu_io_in, 8'h00);
    chk("abort_busy", busy, 1'b0);
    bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (sample_valid || done) bad = 1'b1;
      tick(1);
    end
    chk("abort_quiet", bad, 1'b0);
    start = 1'b1; tick(1); start = 1'b0;
    chk("rerun_rst_seq", cpu_io_in, 8'h02);
    tick(4);
    chk("rerun_first_instr", cpu_io_in, 8'h54);
    tick(1);
    chk("rerun_pulse", cpu_io_in, 8'h55);

    #2 rst = 1'b0;
    #1;
    chk("async_rst_pins", cpu_io_in, 8'h00);
    chk("async_rst_load_ready", load_ready, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    tick(1);
    rst = 1'b1;
    tick(1);
    start = 1'b1; tick(1); start = 1'b0;
    chk("async_rst_count_zero", busy, 1'b0);
    chk("async_rst_count_zero_pins", cpu_io_in, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hidden_cpu_program_feeder.md
Name: hidden_cpu_program_feeder

Overview:
Host-side driver for the 8-bit CPU's pin interface.
- Holds a small program of 6-bit instruction words and drives them onto the CPU input bus: {instr[5:0], cpu_rst, cpu_clk}.
- Generates the CPU clock and reset bits itself.
- Captures the CPU's 8-bit output after every CPU clock edge.
- Sits on the tester/host side of the CPU pins as the instruction source and result collector.

Parameters:
DEPTH, 16, number of program words stored
AW, 4, address width, log2(DEPTH)
RST_CYCLES, 2, full CPU clock periods with cpu_rst held high before the first instruction
HALF_PERIOD, 1, clk cycles per CPU clock phase (low phase and high phase each); must be >= 1

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
load_valid  input  1  program word offered
load_ready  output  1  feeder accepts a program word
load_data  input  6  instruction word; maps to CPU io_in[7:2]
load_clear  input  1  empty program store (IDLE only)
start  input  1  begin a run (IDLE only)
abort  input  1  terminate a run
cpu_io_in  output  8  drives CPU io_in: [7:2] instr, [1] cpu_rst, [0] cpu_clk
cpu_io_out  input  8  CPU io_out
sample  output  8  last captured cpu_io_out
sample_valid  output  1  one-cycle strobe, sample updated
sample_idx  output  AW  program index of the captured sample
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle strobe at run completion

Behaviour:
Reset (rst low, asynchronous):
- State IDLE; count=0, ptr=0; cpu_io_in=8'h00; sample=8'h00.
- sample_valid=0, sample_idx=0, busy=0, done=0, load_ready=1.
- Program memory contents are not reset; they are unreachable because count=0.

States: IDLE, RSTCPU, SETUP, PULSE, FINISH.
- A CPU clock period is SETUP/low phase (HALF_PERIOD clks) followed by PULSE/high phase (HALF_PERIOD clks).

IDLE:
- load_ready = (count != DEPTH).
- load_valid & load_ready: mem[count] <= load_data, count++.
- load_clear: count <= 0; it has priority over load_valid in the same cycle.
- start with count>0: ptr <= 0, go to RSTCPU. start with count==0 is ignored.
- start has priority over load in the same cycle; the word is not accepted.

RSTCPU:
- cpu_io_in[7:2]=0 and cpu_io_in[1]=1.
- cpu_io_in[0] runs RST_CYCLES full periods (low then high).
- Then go to SETUP.

SETUP:
- cpu_io_in = {mem[ptr], 1'b0, 1'b0} for HALF_PERIOD cycles; instruction is stable before the CPU rising edge.

PULSE:
- cpu_io_in = {mem[ptr], 1'b0, 1'b1} for HALF_PERIOD cycles.
- On the last PULSE cycle, register sample <= cpu_io_out and sample_idx <= ptr; sample_valid is high the following cycle.
- Then if ptr == count-1, go to FINISH; else ptr++ and go to SETUP.

FINISH:
- cpu_io_in = 8'h00; done=1 for one cycle; return to IDLE.

Latency and timing:
- Per instruction: 2*HALF_PERIOD clks.
- Total run length, start to done: 1 + 2*HALF_PERIOD*(RST_CYCLES+count) + 1 clks.

abort:
- In any non-IDLE state, go to IDLE next cycle with cpu_io_in=8'h00.
- No sample_valid and no done.
- abort has priority over all transitions.
- abort in IDLE has no effect.

Other rules:
- load_ready=0 and load_valid is ignored while busy.
- Program memory is retained across runs.
- ptr arithmetic is AW+1 bits wide, so count==DEPTH is representable.
- cpu_io_in is driven from registers only, so there are no combinational glitches on the CPU clock bit.

Optional Feature:
Macro FEEDER_LOOP_EN.
- Defined: after the last instruction's PULSE, ptr wraps to 0 and the run re-enters SETUP with no CPU reset in between. It loops until abort; done is never asserted.
- Undefined: the run ends in FINISH as described under Behaviour.

Test Plan:
- Load 6'h15, 6'h2A, 6'h3F; start (RST_CYCLES=2, HALF_PERIOD=1) -> cpu_io_in sequence 02,03,02,03,54,55,A8,A9,FC,FD,00. sample_valid strobes with sample_idx 0,1,2; done one cycle after returning 00; busy falls with done.
- Same program with a CPU model returning cpu_io_out = 8'h10 + index -> sample = 8'h10, 8'h11, 8'h12 in order.
- Load 16 words -> load_ready=0 after the 16th; a 17th load_valid is not written, count stays 16. load_clear -> load_ready=1, count=0.
- start with count=0 -> busy stays 0, cpu_io_in stays 8'h00, no done.
- abort during the second instruction's SETUP -> next cycle cpu_io_in=8'h00, busy=0, no further sample_valid, no done. A new start reruns from index 0 with the CPU reset sequence.
- Drive rst low mid-PULSE (asynchronous, between clk edges) -> cpu_io_in=8'h00 immediately, load_ready=1, count=0. With FEEDER_LOOP_EN and 2 words, sample_idx reads 0,1,0,1 with no reset pattern (02/03) between loops.
